// File: rtl/timer_ctrl.sv
// -----------------------------------------------------------------------------
// timer_ctrl
//   Memory-mapped down-counting timer. Software programs PRESET, then enables
//   the timer through CTRL. The FSM loads COUNT from PRESET and counts down to
//   zero. It then raises irq_pending and either stops (one-shot) or reloads
//   (auto-reload).
//
// Ports
//   clk    : system clock, all state updates on posedge
//   reset  : synchronous, active-high reset
//   addr   : word select (0=CTRL, 1=PRESET, 2=COUNT, 3=reserved)
//   we     : write strobe, committed at the posedge where it is high
//   wdata  : write data
//   rdata  : combinational read data for addr
//   irq    : interrupt request = irq_pending & CTRL.im
//
// CTRL layout: bit0 en, bits2:1 mode (01 auto-reload, anything else one-shot),
//              bit3 im (irq mask). Upper bits read as zero.
// -----------------------------------------------------------------------------
module timer_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       addr,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [1:0]       ADDR_CTRL   = 2'd0;
  localparam logic [1:0]       ADDR_PRESET = 2'd1;
  localparam logic [1:0]       ADDR_COUNT  = 2'd2;
  localparam logic [1:0]       MODE_RELOAD = 2'b01;
  localparam logic [WIDTH-1:0] ONE         = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state, state_next;
  logic             en, en_next;
  logic [1:0]       mode, mode_next;
  logic             im, im_next;
  logic [WIDTH-1:0] preset, preset_next;
  logic [WIDTH-1:0] count, count_next;
  logic             pending, pending_next;

  logic ctrl_wr;
  logic preset_wr;
  logic count_le_one;

  assign ctrl_wr      = we && (addr == ADDR_CTRL);
  assign preset_wr    = we && (addr == ADDR_PRESET);
  // COUNT <= 1 without a wide comparator: every bit above bit0 is zero.
  assign count_le_one = (count[WIDTH-1:1] == '0);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_next   = state;
    en_next      = en;
    mode_next    = mode;
    im_next      = im;
    preset_next  = preset;
    count_next   = count;
    pending_next = pending;

    unique case (state)
      S_IDLE: begin
        if (en) state_next = S_LOAD;
      end
      S_LOAD: begin
        count_next = preset;
        state_next = S_CNT;
      end
      S_CNT: begin
        if (!en) begin
          state_next = S_IDLE;
        end else if (count_le_one) begin
          // Saturate at zero so PRESET=0 never wraps to all-ones.
          count_next   = '0;
          pending_next = 1'b1;
          state_next   = S_INT;
        end else begin
          count_next = count - ONE;
        end
      end
      S_INT: begin
        // Reserved modes 10/11 fall through to one-shot behaviour.
        if (mode == MODE_RELOAD) begin
          pending_next = 1'b0;
          state_next   = S_LOAD;
        end else begin
          en_next    = 1'b0;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // A CTRL write overrides FSM side effects on the CTRL bits and on
    // irq_pending. The state transition above still uses the pre-edge mode.
    if (ctrl_wr) begin
      en_next      = wdata[0];
      mode_next    = wdata[2:1];
      im_next      = wdata[3];
      pending_next = 1'b0;
    end

    // PRESET only reaches COUNT at the next LOAD.
    if (preset_wr) preset_next = wdata;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments, so every register samples the
    // pre-edge values computed above.
    if (reset) begin
      state   <= S_IDLE;
      en      <= 1'b0;
      mode    <= 2'b00;
      im      <= 1'b0;
      preset  <= '0;
      count   <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_next;
      en      <= en_next;
      mode    <= mode_next;
      im      <= im_next;
      preset  <= preset_next;
      count   <= count_next;
      pending <= pending_next;
    end
  end

  // Reads have no side effects.
  always_comb begin
    rdata = '0;
    unique case (addr)
      ADDR_CTRL:   rdata = {{(WIDTH-4){1'b0}}, im, mode, en};
      ADDR_PRESET: rdata = preset;
      ADDR_COUNT:  rdata = count;
      default:     rdata = '0;
    endcase
  end

  assign irq = pending & im;

endmodule

// File: tb/tb_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_timer_ctrl
//   Self-checking bench for timer_ctrl (WIDTH=32).
//   A table of per-cycle vectors covers reset and the basic one-shot flow.
//   Hand-written sequences cover the multi-cycle corner cases.
//   Each checked cycle pushes its expectation when the stimulus is driven.
//   The expectation is popped and compared #1 after the committing posedge.
// -----------------------------------------------------------------------------
module tb_timer_ctrl;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic [1:0]   addr;
  logic         we;
  logic [W-1:0] wdata;
  logic [W-1:0] rdata;
  logic         irq;

  timer_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         we;
    logic [1:0]   addr;
    logic [W-1:0] wdata;
    logic         chk;
    logic [W-1:0] exp_rdata;
    logic         exp_irq;
  } vec_t;

  typedef struct {
    logic [W-1:0] rdata;
    logic         irq;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [W-1:0] got_r, input logic got_i,
                       input logic [W-1:0] exp_r, input logic exp_i);
    checks++;
    if (got_r !== exp_r || got_i !== exp_i) begin
      errors++;
      $display("FAIL %s: got rdata=%h irq=%b, expected rdata=%h irq=%b",
               nm, got_r, got_i, exp_r, exp_i);
    end
  endtask

  // One clock cycle. Inputs are driven at the negedge and held through the
  // next posedge. Outputs are sampled #1 after that posedge.
  task automatic step(input logic r, input logic w, input logic [1:0] a, input logic [W-1:0] d,
                      input logic c, input logic [W-1:0] er, input logic ei, input string nm);
    exp_t  e;
    string n;
    @(negedge clk);
    reset = r;
    we    = w;
    addr  = a;
    wdata = d;
    if (c) begin
      exp_q.push_back('{er, ei});
      name_q.push_back(nm);
    end
    @(posedge clk);
    #1;
    if (c) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      check(n, rdata, irq, e.rdata, e.irq);
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [W-1:0] er, input logic ei, input string nm);
    step(1'b0, 1'b0, a, '0, 1'b1, er, ei, nm);
  endtask

  task automatic wr(input logic [1:0] a, input logic [W-1:0] d, input logic [W-1:0] er,
                    input logic ei, input string nm);
    step(1'b0, 1'b1, a, d, 1'b1, er, ei, nm);
  endtask

  task automatic do_reset(input string nm);
    step(1'b1, 1'b0, 2'd0, '0, 1'b1, '0, 1'b0, nm);
  endtask

  vec_t       vecs[21];
  logic [W-1:0] ar_cnt[4];

  initial begin
    reset = 1'b1;
    we    = 1'b0;
    addr  = 2'd0;
    wdata = '0;

    // rst we addr wdata chk exp_rdata exp_irq
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 32'h0,         1'b1, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 2'd0, 32'h0,         1'b1, 32'h0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 2'd1, 32'h0,         1'b1, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 2'd2, 32'h0,         1'b1, 32'h0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 2'd3, 32'h0,         1'b1, 32'h0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 2'd0, 32'hF,         1'b1, 32'hF, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 2'd0, 32'h0,         1'b1, 32'h0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 2'd0, 32'h0,         1'b1, 32'h0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 2'd1, 32'h3,         1'b1, 32'h3, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 2'd0, 32'h9,         1'b1, 32'h9, 1'b0}; // edge +0
    vecs[10] = '{1'b0, 1'b0, 2'd2, 32'h0,         1'b1, 32'h0, 1'b0}; // +1 IDLE->LOAD
    vecs[11] = '{1'b0, 1'b0, 2'd2, 32'h0,         1'b1, 32'h3, 1'b0}; // +2
    vecs[12] = '{1'b0, 1'b0, 2'd2, 32'h0,         1'b1, 32'h2, 1'b0}; // +3
    vecs[13] = '{1'b0, 1'b0, 2'd2, 32'h0,         1'b1, 32'h1, 1'b0}; // +4
    vecs[14] = '{1'b0, 1'b0, 2'd2, 32'h0,         1'b1, 32'h0, 1'b1}; // +5 irq
    vecs[15] = '{1'b0, 1'b0, 2'd0, 32'h0,         1'b1, 32'h8, 1'b1}; // +6 en cleared
    vecs[16] = '{1'b0, 1'b0, 2'd2, 32'h0,         1'b1, 32'h0, 1'b1};
    vecs[17] = '{1'b0, 1'b1, 2'd0, 32'h8,         1'b1, 32'h8, 1'b0}; // CTRL write clears
    vecs[18] = '{1'b0, 1'b1, 2'd2, 32'h55,        1'b1, 32'h0, 1'b0}; // COUNT write ignored
    vecs[19] = '{1'b0, 1'b1, 2'd3, 32'hFF,        1'b1, 32'h0, 1'b0}; // addr 3 ignored
    vecs[20] = '{1'b0, 1'b1, 2'd0, 32'hFFFF_FFF0, 1'b1, 32'h0, 1'b0}; // upper bits dropped

    for (int i = 0; i < 21; i++)
      step(vecs[i].rst, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].chk,
           vecs[i].exp_rdata, vecs[i].exp_irq, $sformatf("vec%0d", i));

    // Auto-reload, PRESET=2: COUNT 2,1,0,0 repeating, irq pulse every 4 cycles.
    do_reset("ar_reset");
    wr(2'd1, 32'd2, 32'd2, 1'b0, "ar_preset");
    wr(2'd0, 32'hB, 32'hB, 1'b0, "ar_ctrl");
    ar_cnt[0] = 32'd2; ar_cnt[1] = 32'd1; ar_cnt[2] = 32'd0; ar_cnt[3] = 32'd0;
    rd(2'd2, 32'd0, 1'b0, "ar_e1");
    for (int k = 2; k <= 14; k++)
      rd(2'd2, ar_cnt[(k-2)%4], ((k-2)%4) == 2, $sformatf("ar_e%0d", k));

    // Disable mid-count at COUNT=5: decrement still happens, then COUNT freezes.
    do_reset("dis_reset");
    wr(2'd1, 32'd8, 32'd8, 1'b0, "dis_preset");
    wr(2'd0, 32'h9, 32'h9, 1'b0, "dis_ctrl");
    rd(2'd2, 32'd0, 1'b0, "dis_e1");
    for (int k = 2; k <= 5; k++)
      rd(2'd2, 32'(10 - k), 1'b0, $sformatf("dis_e%0d", k));
    wr(2'd0, 32'h8, 32'h8, 1'b0, "dis_off");
    rd(2'd2, 32'd4, 1'b0, "dis_frozen1");
    rd(2'd2, 32'd4, 1'b0, "dis_frozen2");
    wr(2'd0, 32'h9, 32'h9, 1'b0, "dis_reen");
    rd(2'd2, 32'd4, 1'b0, "dis_reen_e1");
    rd(2'd2, 32'd8, 1'b0, "dis_reload");
    rd(2'd2, 32'd7, 1'b0, "dis_count");

    // PRESET=0: LOAD writes 0, and the next edge enters INT without wrapping.
    do_reset("z_reset");
    wr(2'd1, 32'd0, 32'd0, 1'b0, "z_preset");
    wr(2'd0, 32'h9, 32'h9, 1'b0, "z_ctrl");
    rd(2'd2, 32'd0, 1'b0, "z_e1");
    rd(2'd2, 32'd0, 1'b0, "z_load");
    rd(2'd2, 32'd0, 1'b1, "z_int");
    rd(2'd0, 32'h8, 1'b1, "z_ctrl_after");
    rd(2'd2, 32'd0, 1'b1, "z_no_wrap");

    // PRESET rewritten mid-period: this period finishes from 7, next reload is 4.
    do_reset("mp_reset");
    wr(2'd1, 32'd10, 32'd10, 1'b0, "mp_preset");
    wr(2'd0, 32'hB, 32'hB, 1'b0, "mp_ctrl");
    rd(2'd2, 32'd0, 1'b0, "mp_e1");
    for (int k = 2; k <= 5; k++)
      rd(2'd2, 32'(12 - k), 1'b0, $sformatf("mp_e%0d", k));
    wr(2'd1, 32'd4, 32'd4, 1'b0, "mp_rewrite");
    for (int k = 7; k <= 11; k++)
      rd(2'd2, 32'(12 - k), 1'b0, $sformatf("mp_e%0d", k));
    rd(2'd2, 32'd0, 1'b1, "mp_int");
    rd(2'd2, 32'd0, 1'b0, "mp_load");
    rd(2'd2, 32'd4, 1'b0, "mp_reload4");

    // CTRL write on the same edge as one-shot INT: the write keeps en and
    // clears irq, so the FSM passes through IDLE and reloads.
    do_reset("col_reset");
    wr(2'd1, 32'd1, 32'd1, 1'b0, "col_preset");
    wr(2'd0, 32'h9, 32'h9, 1'b0, "col_ctrl");
    rd(2'd2, 32'd0, 1'b0, "col_e1");
    rd(2'd2, 32'd1, 1'b0, "col_e2");
    rd(2'd2, 32'd0, 1'b1, "col_e3");
    wr(2'd0, 32'h9, 32'h9, 1'b0, "col_write");
    rd(2'd2, 32'd0, 1'b0, "col_idle");
    rd(2'd2, 32'd1, 1'b0, "col_reload");

    // im=0: irq stays low while the timer still expires and clears en.
    do_reset("im_reset");
    wr(2'd1, 32'd1, 32'd1, 1'b0, "im_preset");
    wr(2'd0, 32'h1, 32'h1, 1'b0, "im_ctrl");
    rd(2'd2, 32'd0, 1'b0, "im_e1");
    rd(2'd2, 32'd1, 1'b0, "im_e2");
    rd(2'd2, 32'd0, 1'b0, "im_masked");
    rd(2'd0, 32'h0, 1'b0, "im_en_cleared");

    // Reset during INT: irq drops and the timer stays idle.
    do_reset("ri_reset0");
    wr(2'd1, 32'd1, 32'd1, 1'b0, "ri_preset");
    wr(2'd0, 32'h9, 32'h9, 1'b0, "ri_ctrl");
    rd(2'd2, 32'd0, 1'b0, "ri_e1");
    rd(2'd2, 32'd1, 1'b0, "ri_e2");
    rd(2'd2, 32'd0, 1'b1, "ri_int");
    do_reset("ri_reset_in_int");
    rd(2'd0, 32'h0, 1'b0, "ri_ctrl_after");
    rd(2'd1, 32'h0, 1'b0, "ri_preset_after");
    rd(2'd2, 32'h0, 1'b0, "ri_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1, "watchdog");
  end

endmodule
